// File: rtl/scc_sound.sv
// scc_sound: Konami SCC / SCC+ wavetable sound generator, five channels.
// Holds the wave RAM and the channel registers, and mixes the channels into signed PCM.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   clk_en         chip-clock enable that advances the tone logic
//   req/wr/rd      CPU access from the mapper
//   addr/din/mode  CPU access from the mapper
//   dout           registered read data
//   wave_out       registered 15-bit signed mix
// Build option SCC_PLUS_EN: 160-byte wave RAM, and mode=1 selects the SCC+ map.
// Without SCC_PLUS_EN: mode is ignored, the RAM is 128 bytes, and ch4 plays the ch3 wave.
module scc_sound #(
  parameter int CH_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               req,
  input  logic               wr,
  input  logic               rd,
  input  logic [7:0]         addr,
  input  logic [7:0]         din,
  input  logic               mode,
  output logic [7:0]         dout,
  output logic signed [14:0] wave_out
);

`ifdef SCC_PLUS_EN
  localparam int RAM_BYTES = 160;
  logic plus;
  assign plus = mode;
`else
  localparam int RAM_BYTES = 128;
  logic plus;
  logic unused_mode;
  assign plus = 1'b0;
  assign unused_mode = mode;
`endif

  localparam int IW = $clog2(RAM_BYTES);
  localparam int PW = (CH_DIV > 1) ? $clog2(CH_DIV) : 1;

  logic [7:0]  ram [RAM_BYTES];
  logic [11:0] period [5];
  logic [3:0]  vol [5];
  logic [4:0]  enable;
  logic        deform_rst;
  logic [11:0] cnt [5];
  logic [4:0]  phase [5];
  logic [PW-1:0] presc;
  logic        tick;

  logic        ram_wr;
  logic        reg_wr;
  logic        def_wr;
  logic [3:0]  ridx;
  logic        per_wr;
  logic [7:0]  rdata;

  assign ridx   = addr[3:0];
  assign per_wr = reg_wr && (ridx < 4'd10);

  // CH_DIV clk_en pulses per tone step
  assign tick = clk_en && (presc == PW'(CH_DIV - 1));

  // Write decode
  always_comb begin
    ram_wr = 1'b0;
    reg_wr = 1'b0;
    def_wr = 1'b0;
    if (req && wr) begin
      if (plus) begin
        unique case (1'b1)
          addr < 8'hA0:        ram_wr = 1'b1;
          addr[7:5] == 3'b101: reg_wr = 1'b1;
          addr[7:5] == 3'b110: def_wr = 1'b1;
          default: ;
        endcase
      end else begin
        unique case (1'b1)
          !addr[7]:            ram_wr = 1'b1;
          addr[7:5] == 3'b100: reg_wr = 1'b1;
          addr[7:5] == 3'b111: def_wr = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Read decode; the registers are write-only and read back as FF
  always_comb begin
    rdata = 8'hFF;
    if (plus) begin
      if (addr < 8'hA0)
        rdata = ram[IW'(addr)];
    end else begin
      unique case (1'b1)
        !addr[7]:
          rdata = ram[IW'(addr[6:0])];
        addr[7:5] == 3'b101:
          rdata = ram[IW'({2'b11, addr[4:0]})];
        default: ;
      endcase
    end
  end

  // Wave RAM
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RAM_BYTES; i++)
        ram[i] <= '0;
    end else if (ram_wr) begin
      ram[IW'(addr)] <= din;
    end
  end

  // Channel registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 5; c++) begin
        period[c] <= '0;
        vol[c]    <= '0;
      end
      enable     <= '0;
      deform_rst <= 1'b0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        if (per_wr && ridx[3:1] == 3'(c)) begin
          if (ridx[0])
            period[c][11:8] <= din[3:0];
          else
            period[c][7:0] <= din;
        end
        if (reg_wr && ridx == 4'(10 + c))
          vol[c] <= din[3:0];
      end
      if (reg_wr && ridx == 4'hF)
        enable <= din[4:0];
      if (def_wr)
        deform_rst <= din[5];
    end
  end

  // Tone counters and phases
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      for (int c = 0; c < 5; c++) begin
        cnt[c]   <= '0;
        phase[c] <= '0;
      end
    end else begin
      if (clk_en)
        presc <= tick ? '0 : presc + PW'(1);
      for (int c = 0; c < 5; c++) begin
        // deform restart: the written period loads now and the phase rewinds
        if (deform_rst && per_wr && ridx[3:1] == 3'(c)) begin
          cnt[c] <= ridx[0] ? {din[3:0], period[c][7:0]}
                            : {period[c][11:8], din};
          phase[c] <= '0;
        end else if (tick) begin
          if (cnt[c] != '0) begin
            cnt[c] <= cnt[c] - 12'd1;
          end else begin
            cnt[c]   <= period[c];
            phase[c] <= phase[c] + 5'd1;
          end
        end
      end
    end
  end

  // Mixer: reads the RAM before any same-cycle write lands
  logic [IW-1:0]      widx [5];
  logic [7:0]         samp [5];
  logic signed [12:0] prod [5];
  logic signed [14:0] mix;

  always_comb begin
    mix = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4)
        widx[c] = plus ? IW'(8'd128 + 8'(phase[c]))
                       : IW'({2'b11, phase[c]});
      else
        widx[c] = IW'({2'(c), phase[c]});
      samp[c] = ram[widx[c]];
      prod[c] = '0;
      if (enable[c] && period[c] >= 12'd9)
        prod[c] = 13'($signed(samp[c]))
                * 13'($signed({1'b0, vol[c]}));
      mix = mix + {{2{prod[c][12]}}, prod[c]};
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= 8'hFF;
      wave_out <= '0;
    end else begin
      if (req && rd)
        dout <= rdata;
      if (clk_en)
        wave_out <= mix;
    end
  end

endmodule
